ervp_path_arbiter: RTL and testbench
====================================

Name: ervp_path_arbiter

Overview:
- Dynamic controller for a shared mux/demux channel pair.
- NUM_REQ requesters compete for one downstream request path. The arbiter picks a winner (round-robin by default), drives the mux select, and locks the grant until the winner's last beat is accepted.
- Each grant's owner index is queued, so the returning response stream is demuxed back to the correct requester in order.
- Sits between a set of masters and one shared slave/accelerator port.

Parameters:
- NUM_REQ, 4, number of requesters (>=1).
- BW_REQ_DATA, 32, request beat width.
- BW_RSP_DATA, 32, response beat width.
- OWNER_DEPTH, 4, outstanding-transaction depth of the owner FIFO (power of 2, >=2).
- BW_SEL (localparam), REQUIRED_BITWIDTH_INDEX(NUM_REQ), select/owner width (min 1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid_list  in  NUM_REQ  per-requester beat valid
- req_last_list  in  NUM_REQ  per-requester last beat of transaction
- req_data_list  in  NUM_REQ*BW_REQ_DATA  packed request data, requester i at [i*BW_REQ_DATA +: BW_REQ_DATA]
- req_ready_list  out  NUM_REQ  per-requester ready
- out_valid  out  1  shared request valid
- out_last  out  1  shared request last
- out_data  out  BW_REQ_DATA  shared request data
- out_owner  out  BW_SEL  index of current granted requester
- out_ready  in  1  downstream ready
- rsp_valid  in  1  shared response valid
- rsp_last  in  1  last response beat of a transaction
- rsp_data  in  BW_RSP_DATA  shared response data
- rsp_ready  out  1  shared response ready
- rsp_valid_list  out  NUM_REQ  demuxed response valid
- rsp_last_list  out  NUM_REQ  demuxed response last
- rsp_data_list  out  NUM_REQ*BW_RSP_DATA  response data broadcast to all slots
- rsp_ready_list  in  NUM_REQ  per-requester response ready
- busy  out  1  state==BUSY or owner FIFO non-empty
- error_unexpected_rsp  out  1  sticky: rsp_valid seen with owner FIFO empty

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high.
- Reset values:
  - state=IDLE; last_grant=NUM_REQ-1, so requester 0 wins first.
  - Owner FIFO empty; error_unexpected_rsp=0.
  - All *_valid and *_ready outputs are 0; out_owner=0.
- Request FSM:
  - IDLE: if any req_valid and the owner FIFO is not full, latch winner = first set bit scanning from last_grant+1 with wrap-around. Push winner into the owner FIFO and go to BUSY next cycle. This costs one arbitration bubble cycle; all req_ready=0 in IDLE.
  - IDLE with owner FIFO full: no grant; stay in IDLE.
  - BUSY:
    - out_valid=req_valid_list[sel], out_data/out_last are muxed from sel.
    - req_ready_list[sel]=out_ready; all other ready bits are 0.
    - The grant does not change while req_valid deasserts mid-transaction.
    - On (out_valid & out_ready & out_last): last_grant<=sel and go to IDLE.
- Response path: head = owner FIFO head.
  - FIFO non-empty: rsp_valid_list[head]=rsp_valid, rsp_last_list[head]=rsp_last, rsp_ready=rsp_ready_list[head]. All other bits are 0.
  - Response beats may arrive before the corresponding request finishes; routing uses the FIFO only.
  - On (rsp_valid & rsp_ready & rsp_last): pop the FIFO.
  - FIFO empty: rsp_ready=0. If rsp_valid=1, set error_unexpected_rsp (sticky until rst).
- Simultaneous push (grant) and pop (last response) are legal at any occupancy, including full. Full is evaluated before the pop, so there is no same-cycle grant when full.
- NUM_REQ=1: arbitration is trivial; select is constant 0, but the FSM and bubble are kept.
- Reset mid-transaction: state and FIFO are cleared immediately. The partial transaction is abandoned with no downstream flush; the system must reset the downstream block too.

Optional Feature:
- Macro: ERVP_PATH_ARB_FIXED_PRIORITY_EN.
- Defined: the IDLE winner is the lowest-index valid requester; last_grant is unused.
- Undefined (default): round-robin as above.

Decomposition:
- Package ervp_path_arb_pkg holds:
  - state encoding constants (IDLE=1'b0, BUSY=1'b1);
  - owner FIFO pointer width function.
- Sub-module ervp_path_arb_owner_fifo: synchronous FIFO of BW_SEL-bit entries, depth OWNER_DEPTH, with push, pop, full, empty and head, plus same-cycle push/pop support.
- The round-robin picker stays inline.

Test Plan:
- NUM_REQ=4; req0 and req2 valid, single-beat, out_ready=1 -> req0 granted at cycle 2 after bubble, then req2; out_owner shows 0 then 2.
- All four requesters continuously valid, 1-beat each -> grant order 0,1,2,3,0 (fixed-priority build: 0,0,0).
- req1 sends a 3-beat transaction, deasserting valid for 2 cycles between beats 1 and 2 while req3 is valid -> req3 is not granted until req1's last beat is accepted.
- OWNER_DEPTH=2; issue 3 transactions with no responses -> third grant is withheld (FIFO full). Return rsp_last for owner 0 -> third grant issues next IDLE cycle. Responses route to rsp_valid_list bits 0 then 1.
- rsp_valid=1 with no outstanding transaction -> rsp_ready=0 and error_unexpected_rsp=1 until rst.
- Assert rst during BUSY mid-beat -> next cycle all ready/valid=0, busy=0, the next grant goes to requester 0.

Source files
------------

// File: rtl/ervp_path_arb_pkg.sv
// ervp_path_arb_pkg: state encodings and width helpers shared by the path arbiter slice.
package ervp_path_arb_pkg;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    function automatic int required_bitwidth_index(input int num);
        return (num <= 2) ? 1 : $clog2(num);
    endfunction

    function automatic int owner_ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/ervp_path_arbiter_if.sv
// ervp_path_arbiter_if: requester-side, shared request, and shared response signals of the path arbiter.
interface ervp_path_arbiter_if
    import ervp_path_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int BW_REQ_DATA = 32,
    parameter int BW_RSP_DATA = 32
);
    localparam int BW_SEL = required_bitwidth_index(NUM_REQ);

    logic [NUM_REQ-1:0]             req_valid_list;
    logic [NUM_REQ-1:0]             req_last_list;
    logic [NUM_REQ*BW_REQ_DATA-1:0] req_data_list;
    logic [NUM_REQ-1:0]             req_ready_list;
    logic                           out_valid;
    logic                           out_last;
    logic [BW_REQ_DATA-1:0]         out_data;
    logic [BW_SEL-1:0]              out_owner;
    logic                           out_ready;
    logic                           rsp_valid;
    logic                           rsp_last;
    logic [BW_RSP_DATA-1:0]         rsp_data;
    logic                           rsp_ready;
    logic [NUM_REQ-1:0]             rsp_valid_list;
    logic [NUM_REQ-1:0]             rsp_last_list;
    logic [NUM_REQ*BW_RSP_DATA-1:0] rsp_data_list;
    logic [NUM_REQ-1:0]             rsp_ready_list;
    logic                           busy;
    logic                           error_unexpected_rsp;

    // The arbiter itself serves the requesters and the shared port, so it takes the slave view.
    modport slave (
        input  req_valid_list, req_last_list, req_data_list, out_ready,
               rsp_valid, rsp_last, rsp_data, rsp_ready_list,
        output req_ready_list, out_valid, out_last, out_data, out_owner,
               rsp_ready, rsp_valid_list, rsp_last_list, rsp_data_list,
               busy, error_unexpected_rsp
    );

    modport master (
        output req_valid_list, req_last_list, req_data_list, out_ready,
               rsp_valid, rsp_last, rsp_data, rsp_ready_list,
        input  req_ready_list, out_valid, out_last, out_data, out_owner,
               rsp_ready, rsp_valid_list, rsp_last_list, rsp_data_list,
               busy, error_unexpected_rsp
    );

endinterface

// File: rtl/ervp_path_arb_owner_fifo.sv
// ervp_path_arb_owner_fifo: in-order queue of granted owner indices used to steer returning responses.
module ervp_path_arb_owner_fifo
    import ervp_path_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);
    localparam int PW = owner_ptr_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // A pop frees the head slot in the same cycle, so a push is accepted even when full.
    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (PW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/ervp_path_arbiter.sv
// ervp_path_arbiter: grant-locking controller for a shared request mux and response demux.
// Round-robin by default; define ERVP_PATH_ARB_FIXED_PRIORITY_EN for lowest-index-wins arbitration.
module ervp_path_arbiter
    import ervp_path_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int BW_REQ_DATA = 32,
    parameter int BW_RSP_DATA = 32,
    parameter int OWNER_DEPTH = 4
) (
    input logic                clk,
    input logic                rst,
    ervp_path_arbiter_if.slave bus
);
    localparam int BW_SEL = required_bitwidth_index(NUM_REQ);

    logic [0:0]             state_q, state_d;
    logic [BW_SEL-1:0]      sel_q, sel_d;
    logic [BW_SEL-1:0]      last_grant_q, last_grant_d;
    logic                   err_q, err_d;
    logic [BW_SEL-1:0]      winner;
    logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [BW_SEL-1:0]      fifo_head;
    logic [NUM_REQ-1:0]     req_ready, rsp_valid_vec, rsp_last_vec;
    logic                   out_valid, out_last, out_fire, rsp_ready;
    logic [BW_REQ_DATA-1:0] out_data;

`ifdef ERVP_PATH_ARB_FIXED_PRIORITY_EN
    always_comb begin
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid_list[i]) winner = BW_SEL'(i);
        end
    end
`else
    logic found;

    // First pass covers indices after the previous grant, second pass wraps around to the start.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && bus.req_valid_list[i] && (i > int'(last_grant_q))) begin
                winner = BW_SEL'(i);
                found  = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && bus.req_valid_list[i]) begin
                winner = BW_SEL'(i);
                found  = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        fifo_push    = 1'b0;
        if (state_q == IDLE) begin
            if ((|bus.req_valid_list) && !fifo_full) begin
                sel_d     = winner;
                fifo_push = 1'b1;
                state_d   = BUSY;
            end
        end else if (out_fire) begin
            last_grant_d = sel_q;
            state_d      = IDLE;
        end
    end

    always_comb begin
        req_ready = '0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        if (state_q == BUSY) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (sel_q == BW_SEL'(i)) begin
                    out_valid    = bus.req_valid_list[i];
                    out_last     = bus.req_last_list[i];
                    out_data     = bus.req_data_list[i*BW_REQ_DATA +: BW_REQ_DATA];
                    req_ready[i] = bus.out_ready;
                end
            end
        end
    end

    assign out_fire = out_valid & bus.out_ready & out_last;

    // Responses are steered purely by the oldest outstanding owner, independent of request progress.
    always_comb begin
        rsp_valid_vec = '0;
        rsp_last_vec  = '0;
        rsp_ready     = 1'b0;
        if (!fifo_empty) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (fifo_head == BW_SEL'(i)) begin
                    rsp_valid_vec[i] = bus.rsp_valid;
                    rsp_last_vec[i]  = bus.rsp_last;
                    rsp_ready        = bus.rsp_ready_list[i];
                end
            end
        end
    end

    assign fifo_pop = bus.rsp_valid & rsp_ready & bus.rsp_last;
    assign err_d    = err_q | (bus.rsp_valid & fifo_empty);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            last_grant_q <= BW_SEL'(NUM_REQ - 1);
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
        end
    end

    ervp_path_arb_owner_fifo #(
        .DEPTH (OWNER_DEPTH),
        .WIDTH (BW_SEL)
    ) u_owner_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .data_i  (sel_d),
        .pop_i   (fifo_pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    assign bus.req_ready_list       = req_ready;
    assign bus.out_valid            = out_valid;
    assign bus.out_last             = out_last;
    assign bus.out_data             = out_data;
    assign bus.out_owner            = sel_q;
    assign bus.rsp_ready            = rsp_ready;
    assign bus.rsp_valid_list       = rsp_valid_vec;
    assign bus.rsp_last_list        = rsp_last_vec;
    assign bus.rsp_data_list        = {NUM_REQ{bus.rsp_data}};
    assign bus.busy                 = (state_q == BUSY) | ~fifo_empty;
    assign bus.error_unexpected_rsp = err_q;

endmodule

// File: tb/tb_ervp_path_arbiter.sv
// tb_ervp_path_arbiter: scripted requesters and responder with grant/response scoreboards.
`timescale 1ns/1ps
module tb_ervp_path_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int BW_REQ_DATA = 32;
    localparam int BW_RSP_DATA = 32;
    localparam int OWNER_DEPTH = 2;
    localparam int MAX_BEATS   = 8;

    typedef struct packed {
        logic [1:0]  owner;
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic clk;
    logic rst;
    int   testsRun;
    int   testsFailed;

    beat_t      expQ[$];
    logic [1:0] rspQ[$];

    logic [31:0] beatData [NUM_REQ][MAX_BEATS];
    logic        beatLast [NUM_REQ][MAX_BEATS];
    int          beatGap  [NUM_REQ][MAX_BEATS];
    int          beatCount[NUM_REQ];
    int          beatPtr  [NUM_REQ];
    int          gapCnt   [NUM_REQ];
    int          txDone;
    int          rspDone;
    logic        rspEn;

    ervp_path_arbiter_if #(
        .NUM_REQ     (NUM_REQ),
        .BW_REQ_DATA (BW_REQ_DATA),
        .BW_RSP_DATA (BW_RSP_DATA)
    ) bus ();

    ervp_path_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .BW_REQ_DATA (BW_REQ_DATA),
        .BW_RSP_DATA (BW_RSP_DATA),
        .OWNER_DEPTH (OWNER_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached before summary");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearStimulus();
        for (int r = 0; r < NUM_REQ; r++) begin
            beatCount[r] = 0;
            beatPtr[r]   = 0;
            gapCnt[r]    = 0;
        end
        txDone  = 0;
        rspDone = 0;
    endtask

    // Queue one beat on requester r; when expectIt is set the beat (and its response on last) is scoreboarded.
    task automatic addBeat(input int r, input logic [31:0] data, input logic last, input int gap, input bit expectIt);
        beat_t e;
        beatData[r][beatCount[r]] = data;
        beatLast[r][beatCount[r]] = last;
        beatGap[r][beatCount[r]]  = gap;
        beatCount[r]++;
        if (expectIt) begin
            e.owner = 2'(r);
            e.data  = data;
            e.last  = last;
            expQ.push_back(e);
            if (last) rspQ.push_back(2'(r));
        end
    endtask

    task automatic applyStimulus();
        logic [NUM_REQ-1:0]             v;
        logic [NUM_REQ-1:0]             l;
        logic [NUM_REQ*BW_REQ_DATA-1:0] d;
        v = '0;
        l = '0;
        d = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (gapCnt[r] > 0) begin
                gapCnt[r]--;
            end else if (beatPtr[r] < beatCount[r]) begin
                v[r] = 1'b1;
                l[r] = beatLast[r][beatPtr[r]];
                d[r*BW_REQ_DATA +: BW_REQ_DATA] = beatData[r][beatPtr[r]];
            end
        end
        bus.req_valid_list = v;
        bus.req_last_list  = l;
        bus.req_data_list  = d;
        bus.rsp_valid      = rspEn && (txDone > rspDone);
        bus.rsp_last       = bus.rsp_valid;
        bus.rsp_data       = $urandom();
    endtask

    task automatic sampleOutputs();
        beat_t      e;
        logic [1:0] o;
        if (bus.out_valid && bus.out_ready) begin
            checkOutput("beat_expected", 64'(expQ.size() != 0), 1);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                checkOutput("beat_owner", bus.out_owner, e.owner);
                checkOutput("beat_data", bus.out_data, e.data);
                checkOutput("beat_last", bus.out_last, e.last);
                checkOutput("beat_ready_onehot", bus.req_ready_list, 64'(4'b0001 << e.owner));
            end
            if (bus.out_last) txDone++;
        end
        for (int r = 0; r < NUM_REQ; r++) begin
            if (bus.req_valid_list[r] && bus.req_ready_list[r]) begin
                gapCnt[r] = beatGap[r][beatPtr[r]];
                beatPtr[r]++;
            end
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
            checkOutput("rsp_expected", 64'(rspQ.size() != 0), 1);
            if (rspQ.size() != 0) begin
                o = rspQ.pop_front();
                checkOutput("rsp_route", bus.rsp_valid_list, 64'(4'b0001 << o));
                checkOutput("rsp_last_route", bus.rsp_last_list, 64'(4'b0001 << o));
                checkOutput("rsp_data_bcast", bus.rsp_data_list[int'(o)*BW_RSP_DATA +: BW_RSP_DATA], bus.rsp_data);
            end
            if (bus.rsp_last) rspDone++;
        end
    endtask

    task automatic step();
        applyStimulus();
        @(negedge clk);
        sampleOutputs();
        @(posedge clk);
        #1;
    endtask

    function automatic bit allDone();
        bit done;
        done = (expQ.size() == 0) && (rspQ.size() == 0) && (txDone == rspDone);
        for (int r = 0; r < NUM_REQ; r++) begin
            if (beatPtr[r] != beatCount[r]) done = 1'b0;
        end
        return done;
    endfunction

    task automatic runUntilDone(input string tag, input int budget);
        int c;
        c = 0;
        while (!allDone() && c < budget) begin
            step();
            c++;
        end
        checkOutput(tag, 64'(allDone()), 1);
        repeat (2) step();
    endtask

    task automatic checkResetState();
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_req_ready", bus.req_ready_list, 0);
        checkOutput("rst_rsp_ready", bus.rsp_ready, 0);
        checkOutput("rst_rsp_valid_list", bus.rsp_valid_list, 0);
        checkOutput("rst_out_owner", bus.out_owner, 0);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_error", bus.error_unexpected_rsp, 0);
    endtask

    task automatic applyReset();
        rst = 1'b1;
        clearStimulus();
        expQ.delete();
        rspQ.delete();
        applyStimulus();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkResetState();
        @(posedge clk);
        #1;
    endtask

    initial begin
        testsRun           = 0;
        testsFailed        = 0;
        rspEn              = 1'b1;
        rst                = 1'b1;
        bus.out_ready      = 1'b1;
        bus.rsp_ready_list = '1;
        clearStimulus();
        applyStimulus();
        @(posedge clk);
        #1;
        applyReset();

        // Two single-beat requesters: bubble cycle, then 0 followed by 2.
        addBeat(0, 32'hA000_0000, 1'b1, 0, 1'b1);
        addBeat(2, 32'hA000_0002, 1'b1, 0, 1'b1);
        applyStimulus();
        @(negedge clk);
        checkOutput("bubble_out_valid", bus.out_valid, 0);
        checkOutput("bubble_req_ready", bus.req_ready_list, 0);
        checkOutput("bubble_busy", bus.busy, 0);
        sampleOutputs();
        @(posedge clk);
        #1;
        applyStimulus();
        @(negedge clk);
        checkOutput("first_grant_valid", bus.out_valid, 1);
        checkOutput("first_grant_owner", bus.out_owner, 0);
        checkOutput("first_grant_busy", bus.busy, 1);
        sampleOutputs();
        @(posedge clk);
        #1;
        runUntilDone("t1_done", 100);

        // All requesters continuously valid.
        applyReset();
`ifdef ERVP_PATH_ARB_FIXED_PRIORITY_EN
        addBeat(0, 32'hB000_0000, 1'b1, 0, 1'b1);
        addBeat(0, 32'hB000_0010, 1'b1, 0, 1'b1);
        addBeat(1, 32'hB000_0001, 1'b1, 0, 1'b1);
        addBeat(2, 32'hB000_0002, 1'b1, 0, 1'b1);
        addBeat(3, 32'hB000_0003, 1'b1, 0, 1'b1);
`else
        addBeat(0, 32'hB000_0000, 1'b1, 0, 1'b1);
        addBeat(1, 32'hB000_0001, 1'b1, 0, 1'b1);
        addBeat(2, 32'hB000_0002, 1'b1, 0, 1'b1);
        addBeat(3, 32'hB000_0003, 1'b1, 0, 1'b1);
        addBeat(0, 32'hB000_0010, 1'b1, 0, 1'b1);
`endif
        runUntilDone("t2_done", 200);

        // Three-beat transaction with a two-cycle valid gap must keep the grant against req3.
        addBeat(1, 32'hC000_0100, 1'b0, 2, 1'b1);
        addBeat(1, 32'hC000_0101, 1'b0, 0, 1'b1);
        addBeat(1, 32'hC000_0102, 1'b1, 0, 1'b1);
        addBeat(3, 32'hC000_0300, 1'b1, 0, 1'b1);
        runUntilDone("t3_done", 200);

        // Owner FIFO full: third grant withheld until a response pops.
        rspEn = 1'b0;
        addBeat(0, 32'hD000_0000, 1'b1, 0, 1'b1);
        addBeat(1, 32'hD000_0001, 1'b1, 0, 1'b1);
        addBeat(2, 32'hD000_0002, 1'b1, 0, 1'b1);
        repeat (8) step();
        applyStimulus();
        @(negedge clk);
        checkOutput("full_withheld_valid", bus.out_valid, 0);
        checkOutput("full_withheld_ready", bus.req_ready_list, 0);
        checkOutput("full_busy", bus.busy, 1);
        sampleOutputs();
        @(posedge clk);
        #1;
        rspEn = 1'b1;
        applyStimulus();
        @(negedge clk);
        checkOutput("full_rsp_head0", bus.rsp_valid_list, 4'b0001);
        checkOutput("full_rsp_ready", bus.rsp_ready, 1);
        sampleOutputs();
        @(posedge clk);
        #1;
        applyStimulus();
        @(negedge clk);
        checkOutput("regrant_bubble", bus.out_valid, 0);
        sampleOutputs();
        @(posedge clk);
        #1;
        applyStimulus();
        @(negedge clk);
        checkOutput("third_grant_valid", bus.out_valid, 1);
        checkOutput("third_grant_owner", bus.out_owner, 2);
        sampleOutputs();
        @(posedge clk);
        #1;
        runUntilDone("t4_done", 100);

        // Response with nothing outstanding.
        bus.rsp_valid = 1'b1;
        bus.rsp_last  = 1'b1;
        @(negedge clk);
        checkOutput("unexp_rsp_ready", bus.rsp_ready, 0);
        checkOutput("unexp_rsp_valid_list", bus.rsp_valid_list, 0);
        @(posedge clk);
        #1;
        bus.rsp_valid = 1'b0;
        bus.rsp_last  = 1'b0;
        @(negedge clk);
        checkOutput("unexp_err_set", bus.error_unexpected_rsp, 1);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("unexp_err_sticky", bus.error_unexpected_rsp, 1);
        @(posedge clk);
        #1;

        // Reset mid-transaction abandons the grant and restarts arbitration at requester 0.
        addBeat(2, 32'hE000_0200, 1'b0, 0, 1'b1);
        addBeat(2, 32'hE000_0201, 1'b0, 0, 1'b0);
        addBeat(2, 32'hE000_0202, 1'b1, 0, 1'b0);
        step();
        step();
        applyStimulus();
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        @(negedge clk);
        checkOutput("mid_beat_valid", bus.out_valid, 1);
        checkOutput("mid_beat_busy", bus.busy, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abandoned_beat_seen", 64'(expQ.size()), 0);
        clearStimulus();
        expQ.delete();
        rspQ.delete();
        applyStimulus();
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkResetState();
        @(posedge clk);
        #1;
        addBeat(0, 32'hF000_0000, 1'b1, 0, 1'b1);
        addBeat(3, 32'hF000_0003, 1'b1, 0, 1'b1);
        runUntilDone("t6_done", 100);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
